// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the display source scheduler and scan controller
package display_pkg;
   typedef enum logic [1:0] {IDLE, CONVERT, SHOW} state_t;
   localparam logic [3:0] BLANK_NIBBLE = 4'hF;
   localparam int BCD_DIGITS = 5;
   localparam int DISP_DIGITS = 8;
   localparam int BCD_W = 4 * BCD_DIGITS;
   function automatic int rr_next(input logic [2:0] p, input int k, input int n);
      int s;
      s = int'(p) + k;
      return s >= n ? s - n : s;
   endfunction
endpackage

// File: rtl/display_source_scheduler_bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble converter, one shift per clock, DATA_W clocks per value
module bin2bcd_seq
   import display_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clock_100Mhz,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] value,
   output logic              done,
   output logic [BCD_W-1:0]  bcd
);
   localparam int SR_W = BCD_W + DATA_W;
   localparam int CNT_W = $clog2(DATA_W + 1);
   logic [SR_W-1:0]  sr, adj, shifted;
   logic [CNT_W-1:0] cnt;
   // add-3 correction on every BCD nibble that would overflow past 9 after the shift
   always_comb begin
      adj = sr;
      for (int i = 0; i < BCD_DIGITS; i++)
         adj[DATA_W+4*i +: 4] = sr[DATA_W+4*i +: 4] >= 4'd5 ? sr[DATA_W+4*i +: 4] + 4'd3 : sr[DATA_W+4*i +: 4];
      shifted = adj << 1;
   end
   // load on start, then shift until the count expires; last shift publishes the result
   always_ff @(posedge clock_100Mhz) begin
      if (reset) begin
         sr   <= '0;
         cnt  <= '0;
         done <= 1'b0;
         bcd  <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            sr  <= {{BCD_W{1'b0}}, value};
            cnt <= CNT_W'(DATA_W);
         end else if (cnt != '0) begin
            sr  <= shifted;
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
               done <= 1'b1;
               bcd  <= shifted[SR_W-1 -: BCD_W];
            end
         end
      end
   end
endmodule

// File: rtl/display_source_scheduler.sv
// display_source_scheduler: round-robin sharing of the 8-digit display among binary requesters
module display_source_scheduler
   import display_pkg::*;
#(
   parameter int NUM_SRC      = 4,
   parameter int DATA_W       = 16,
   parameter int DWELL_CYCLES = 100000000
) (
   input  logic                      clock_100Mhz,
   input  logic                      reset,
   input  logic [NUM_SRC-1:0]        req,
   input  logic [NUM_SRC*DATA_W-1:0] src_value,
   input  logic                      freeze,
   output logic [NUM_SRC-1:0]        grant,
   output logic                      busy,
   output logic [2:0]                src_id,
   output logic [31:0]               bcd_digits,
   output logic                      digits_valid
);
   localparam int CNT_W = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
   state_t           state, state_nx;
   logic [2:0]       ptr, pick, cur_id;
   logic [7:0]       req_x;
   logic             hit, start, done;
   logic [BCD_W-1:0] bcd;
   logic [CNT_W-1:0] dwell;
   // search upward from the last granted source so every held requester gets a turn
   always_comb begin
      req_x = 8'(req);
      hit   = 1'b0;
      pick  = ptr;
      for (int k = 1; k <= NUM_SRC; k++)
         if (!hit && req_x[3'(rr_next(ptr, k, NUM_SRC))]) begin
            hit  = 1'b1;
            pick = 3'(rr_next(ptr, k, NUM_SRC));
         end
   end
   assign start = state == IDLE && hit;
   bin2bcd_seq #(.DATA_W(DATA_W)) u_conv (
      .clock_100Mhz(clock_100Mhz),
      .reset       (reset),
      .start       (start),
      .value       (src_value[int'(pick)*DATA_W +: DATA_W]),
      .done        (done),
      .bcd         (bcd)
   );
   // state register
   always_ff @(posedge clock_100Mhz) begin
      if (reset) state <= IDLE;
      else state <= state_nx;
   end
   // next state: grant from IDLE, leave CONVERT on converter done, leave SHOW after the unfrozen dwell
   always_comb begin
      state_nx = state == IDLE    ? (hit ? CONVERT : IDLE) :
                 state == CONVERT ? (done ? SHOW : CONVERT) :
                 (!freeze && dwell == CNT_W'(DWELL_CYCLES - 1)) ? IDLE : SHOW;
   end
   // outputs: display is occupied whenever a value is converting or dwelling
   always_comb begin
      busy = state != IDLE;
   end
   // arbiter pointer, grant pulse, displayed value and dwell counter
   always_ff @(posedge clock_100Mhz) begin
      if (reset) begin
         ptr          <= 3'(NUM_SRC - 1);
         cur_id       <= '0;
         grant        <= '0;
         src_id       <= '0;
         bcd_digits   <= '0;
         digits_valid <= 1'b0;
         dwell        <= '0;
      end else begin
         grant        <= start ? NUM_SRC'(1) << pick : '0;
         digits_valid <= 1'b0;
         if (start) begin
            ptr    <= pick;
            cur_id <= pick;
         end
         if (state == CONVERT && done) begin
            bcd_digits   <= {BLANK_NIBBLE, 1'b0, cur_id, BLANK_NIBBLE, bcd};
            src_id       <= cur_id;
            digits_valid <= 1'b1;
            dwell        <= '0;
         end else if (state == SHOW && !freeze) begin
            dwell <= dwell + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_display_source_scheduler.sv
// tb_display_source_scheduler: randomized scoreboard bench against a dwell-budget reference model
module tb_display_source_scheduler;
   localparam int N = 4;
   localparam int W = 16;
   localparam int D = 8;
   logic             clock_100Mhz = 1'b0;
   logic             reset = 1'b1;
   logic             freeze = 1'b0;
   logic [N-1:0]     req = '0;
   logic [N*W-1:0]   src_value = '0;
   logic [N-1:0]     grant;
   logic             busy;
   logic [2:0]       src_id;
   logic [31:0]      bcd_digits;
   logic             digits_valid;
   typedef struct {logic [N-1:0] g; int at;} gexp_t;
   typedef struct {logic [31:0] word; logic [2:0] id; int at;} dexp_t;
   gexp_t gq[$];
   dexp_t dq[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int conv_left = 0;
   int dwell_left = 0;
   int ptr = N - 1;
   logic [31:0] shown = '0;
   logic [2:0]  shown_id = '0;
   logic [31:0] pending;

   always #5 clock_100Mhz = ~clock_100Mhz;

   display_source_scheduler #(.NUM_SRC(N), .DATA_W(W), .DWELL_CYCLES(D)) dut (
      .clock_100Mhz(clock_100Mhz),
      .reset       (reset),
      .req         (req),
      .src_value   (src_value),
      .freeze      (freeze),
      .grant       (grant),
      .busy        (busy),
      .src_id      (src_id),
      .bcd_digits  (bcd_digits),
      .digits_valid(digits_valid)
   );

   function automatic logic [19:0] to_bcd(input int v);
      logic [19:0] r;
      int x;
      x = v;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // reference model: a grant costs W+1 edges of conversion plus D unfrozen dwell edges
   initial begin
      int idx;
      logic [W-1:0] v;
      forever begin
         @(posedge clock_100Mhz);
         cyc++;
         if (reset) begin
            conv_left = 0;
            dwell_left = 0;
            ptr = N - 1;
            shown = '0;
            shown_id = '0;
            gq.delete();
            dq.delete();
         end else if (conv_left > 0) begin
            conv_left--;
            if (conv_left == 0) begin
               shown = pending;
               shown_id = pending[26:24];
               dwell_left = D;
            end
         end else if (dwell_left > 0) begin
            if (!freeze) dwell_left--;
         end else if (req != 0) begin
            idx = -1;
            for (int k = 1; k <= N; k++)
               if (idx < 0 && req[(ptr + k) % N]) idx = (ptr + k) % N;
            v = src_value[idx*W +: W];
            pending = {4'hF, 1'b0, 3'(idx), 4'hF, to_bcd(int'(v))};
            ptr = idx;
            conv_left = W + 1;
            gq.push_back('{g: N'(1) << idx, at: cyc});
            dq.push_back('{word: pending, id: 3'(idx), at: cyc + W + 1});
         end
      end
   end

   // monitor: pops expectations whenever the DUT pulses grant or digits_valid
   initial begin
      gexp_t ge;
      dexp_t de;
      forever begin
         @(negedge clock_100Mhz);
         chk("busy", 32'(busy), 32'(conv_left > 0 || dwell_left > 0));
         chk("bcd_digits", bcd_digits, shown);
         chk("src_id", 32'(src_id), 32'(shown_id));
         if (gq.size() > 0 && gq[0].at < cyc) begin
            ge = gq.pop_front();
            chk("grant_missed", 32'(cyc), 32'(ge.at));
         end
         if (dq.size() > 0 && dq[0].at < cyc) begin
            de = dq.pop_front();
            chk("valid_missed", 32'(cyc), 32'(de.at));
         end
         if (grant != 0) begin
            if (gq.size() == 0) chk("grant_unexpected", 32'(grant), 32'(0));
            else begin
               ge = gq.pop_front();
               chk("grant", 32'(grant), 32'(ge.g));
               chk("grant_time", 32'(cyc), 32'(ge.at));
            end
         end
         if (digits_valid) begin
            if (dq.size() == 0) chk("valid_unexpected", 32'(digits_valid), 32'(0));
            else begin
               de = dq.pop_front();
               chk("valid_word", bcd_digits, de.word);
               chk("valid_id", 32'(src_id), 32'(de.id));
               chk("valid_time", 32'(cyc), 32'(de.at));
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock_100Mhz);
   endtask

   task automatic wait_grant(input int limit);
      int t = 0;
      while (grant == 0 && t < limit) begin
         @(negedge clock_100Mhz);
         t++;
      end
      if (grant == 0) begin
         checks++;
         errors++;
         $display("FAIL wait_grant: no grant within %0d cycles", limit);
      end
   endtask

   task automatic wait_valid(input int limit);
      int t = 0;
      while (!digits_valid && t < limit) begin
         @(negedge clock_100Mhz);
         t++;
      end
      if (!digits_valid) begin
         checks++;
         errors++;
         $display("FAIL wait_valid: no digits_valid within %0d cycles", limit);
      end
   endtask

   task automatic wait_idle(input int limit);
      int t = 0;
      while (busy && t < limit) begin
         @(negedge clock_100Mhz);
         t++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: still busy after %0d cycles", limit);
      end
   endtask

   initial begin
      int cnt;
      tick(3);
      chk("rst_grant", 32'(grant), 32'(0));
      chk("rst_valid", 32'(digits_valid), 32'(0));
      reset = 1'b0;
      tick(2);
      // single request from source 2
      src_value[2*W +: W] = 16'd1234;
      req = 4'b0100;
      wait_grant(5);
      chk("single_grant", 32'(grant), 32'h4);
      req = '0;
      wait_valid(30);
      chk("single_word", bcd_digits, 32'hF2F01234);
      chk("single_id", 32'(src_id), 32'd2);
      tick(D - 1);
      chk("single_busy_last", 32'(busy), 32'd1);
      tick(1);
      chk("single_busy_off", 32'(busy), 32'd0);
      // round-robin from a fresh reset
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      for (int i = 0; i < N; i++) src_value[i*W +: W] = W'(100 * i + 7);
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_grant(40);
         chk("rr_order", 32'(grant), 32'(1) << (i % N));
         tick(1);
      end
      req = '0;
      wait_idle(40);
      // extremes on source 0
      src_value[0 +: W] = 16'd65535;
      req = 4'b0001;
      wait_grant(5);
      req = '0;
      wait_valid(30);
      chk("max_word", bcd_digits, 32'hF0F65535);
      wait_idle(20);
      src_value[0 +: W] = 16'd0;
      req = 4'b0001;
      wait_grant(5);
      req = '0;
      wait_valid(30);
      chk("zero_word", bcd_digits, 32'hF0F00000);
      wait_idle(20);
      // freeze holds SHOW
      src_value[1*W +: W] = 16'd4321;
      req = 4'b0010;
      wait_grant(5);
      req = 4'b1111;
      wait_valid(30);
      tick(3);
      freeze = 1'b1;
      cnt = 0;
      repeat (20) begin
         tick(1);
         if (grant != 0) cnt++;
      end
      chk("freeze_no_grant", 32'(cnt), 32'd0);
      freeze = 1'b0;
      cnt = 0;
      while (busy && cnt < 50) begin
         tick(1);
         cnt++;
      end
      chk("freeze_release", 32'(cnt), 32'd5);
      wait_grant(5);
      req = '0;
      wait_idle(60);
      // reset in the middle of a conversion
      req = 4'b0100;
      wait_grant(5);
      req = '0;
      tick(5);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_digits", bcd_digits, 32'd0);
      chk("midrst_id", 32'(src_id), 32'd0);
      src_value[0 +: W] = 16'd9876;
      req = 4'b1111;
      wait_grant(5);
      chk("midrst_grant", 32'(grant), 32'h1);
      req = '0;
      src_value = {$urandom, $urandom};
      wait_valid(30);
      chk("dropped_word", bcd_digits, 32'hF0F09876);
      cnt = 0;
      repeat (20) begin
         tick(1);
         if (grant != 0) cnt++;
      end
      chk("dropped_no_regrant", 32'(cnt), 32'd0);
      // randomized traffic
      repeat (1500) begin
         tick(1);
         req = N'($urandom);
         freeze = $urandom_range(0, 9) == 0;
         src_value = {$urandom, $urandom};
         reset = $urandom_range(0, 299) == 0;
      end
      reset = 1'b0;
      freeze = 1'b0;
      req = 4'b0011;
      wait_grant(200);
      req = '0;
      wait_idle(200);
      // idle hold keeps the last display
      cnt = 0;
      repeat (100) begin
         tick(1);
         if (digits_valid) cnt++;
      end
      chk("idle_no_valid", 32'(cnt), 32'd0);
      chk("idle_hold", bcd_digits, shown);
      tick(2);
      chk("grant_queue_empty", 32'(gq.size()), 32'd0);
      chk("valid_queue_empty", 32'(dq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
